// File: rtl/key_step_pkg.sv
// Shared types for the manual-step key conditioner: FSM state encoding and
// the counter width helper.
package key_step_pkg;

  typedef enum logic [2:0] {
    RELEASED     = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } key_state_t;

  // Bits needed to count 0 .. max(a,b,c)-1.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_step_debounce_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, with a selectable
// value loaded on synchronous active-low reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= RESET_VAL;
      q     <= RESET_VAL;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/key_step_debounce.sv
// Manual-clock pushbutton conditioner: synchronizes and debounces the
// active-low key, emits step/release pulses, a stretched step level and auto-repeat.
module key_step_debounce
  import key_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned STEP_HIGH       = 2500000
) (
  input  logic osc_50,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_clock
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned STR_W = $clog2(STEP_HIGH + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STEP_HIGH);

  logic             key_sync;
  logic             pressed;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [STR_W-1:0] stretch;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_key_sync (
    .clk    (osc_50),
    .reset_n(reset_n),
    .d      (key_raw),
    .q      (key_sync)
  );

  assign pressed    = ~key_sync;
  assign step_clock = (stretch != '0);

  // Step events override the stretch countdown below via last-assignment-wins.
  always_ff @(posedge osc_50) begin
    if (!reset_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      stretch       <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (stretch != '0) stretch <= stretch - 1'b1;

      case (state)
        RELEASED: begin
          if (pressed) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!pressed) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= HELD;
            cnt         <= '0;
            key_level   <= 1'b1;
            press_pulse <= 1'b1;
            stretch     <= STR_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          if (!pressed) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (REPEAT_EN != 0) begin
            if (cnt == DLY_LAST) begin
              state       <= REPEAT;
              cnt         <= '0;
              press_pulse <= 1'b1;
              stretch     <= STR_LOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        REPEAT: begin
          if (!pressed) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (cnt == PER_LAST) begin
            cnt         <= '0;
            press_pulse <= 1'b1;
            stretch     <= STR_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE_WAIT: begin
          if (pressed) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state         <= RELEASED;
            cnt           <= '0;
            key_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state     <= RELEASED;
          cnt       <= '0;
          key_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_step_debounce.sv
// Directed bench for key_step_debounce: expected pulse cycles are queued when
// stimulus is driven and compared cycle by cycle by a negedge monitor.
module tb_key_step_debounce;

  localparam int DEB   = 8;
  localparam int RDLY  = 40;
  localparam int RPER  = 16;
  localparam int SHIGH = 4;

  logic osc_50 = 1'b0;
  logic reset_n;
  logic key_raw;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic step_clock;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   press_q[$];
  int   rel_q[$];
  logic mon_en      = 1'b0;
  logic rst_at_edge = 1'b0;
  logic step_valid  = 1'b0;
  int   last_step   = 0;

  key_step_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_EN      (1),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER),
    .STEP_HIGH      (SHIGH)
  ) dut (
    .osc_50       (osc_50),
    .reset_n      (reset_n),
    .key_raw      (key_raw),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_clock   (step_clock)
  );

  always #10 osc_50 = ~osc_50;

  always @(posedge osc_50) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !reset_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge osc_50);
  endtask

  // Scoreboard: pops expected events when their cycle arrives; models step_clock.
  always @(negedge osc_50) begin
    logic exp_p;
    logic exp_r;
    logic exp_s;
    int   dummy;
    if (mon_en) begin
      if (rst_at_edge) step_valid = 1'b0;
      exp_p = (press_q.size() != 0) && (press_q[0] == cyc);
      if (exp_p) begin
        dummy      = press_q.pop_front();
        last_step  = cyc;
        step_valid = 1'b1;
      end
      exp_r = (rel_q.size() != 0) && (rel_q[0] == cyc);
      if (exp_r) dummy = rel_q.pop_front();
      exp_s = step_valid && ((cyc - last_step) < SHIGH);
      check("press_pulse", press_pulse, exp_p);
      check("release_pulse", release_pulse, exp_r);
      check("step_clock", step_clock, exp_s);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    key_raw = 1'b0;
    repeat (3) @(negedge osc_50);
    check("rst_key_level", key_level, 0);
    check("rst_press", press_pulse, 0);
    check("rst_release", release_pulse, 0);
    check("rst_step", step_clock, 0);
    mon_en = 1'b1;

    // Reset exit with key already held.
    n = cyc;
    reset_n = 1'b1;
    press_q.push_back(n + 11);
    wait_until(n + 10); check("rstexit_level_pre", key_level, 0);
    wait_until(n + 11); check("rstexit_level", key_level, 1);
    wait_until(n + 20); key_raw = 1'b1; rel_q.push_back(n + 31);
    wait_until(n + 30); check("rstexit_rel_pre", key_level, 1);
    wait_until(n + 31); check("rstexit_rel", key_level, 0);
    wait_until(n + 36);

    // Clean press, 30 cycles held.
    n = cyc;
    key_raw = 1'b0;
    press_q.push_back(n + 11);
    wait_until(n + 10); check("clean_level_pre", key_level, 0);
    wait_until(n + 11); check("clean_level", key_level, 1);
    wait_until(n + 30); key_raw = 1'b1; rel_q.push_back(n + 41);
    wait_until(n + 40); check("clean_rel_pre", key_level, 1);
    wait_until(n + 41); check("clean_rel", key_level, 0);
    wait_until(n + 46);

    // Bounce: 3-cycle toggles never reach acceptance.
    for (int i = 0; i < 42; i++) begin
      key_raw = (((i / 3) % 2) == 1);
      @(negedge osc_50);
    end
    check("bounce_level", key_level, 0);
    n = cyc;
    key_raw = 1'b0;
    press_q.push_back(n + 11);
    wait_until(n + 11); check("bounce_settle_level", key_level, 1);
    wait_until(n + 20); key_raw = 1'b1; rel_q.push_back(n + 31);
    wait_until(n + 36);

    // Auto-repeat while held for 120 cycles.
    n = cyc;
    key_raw = 1'b0;
    press_q.push_back(n + 11);
    press_q.push_back(n + 51);
    for (int k = 1; k <= 4; k++) press_q.push_back(n + 51 + k * RPER);
    wait_until(n + 52); check("repeat_level", key_level, 1);
    wait_until(n + 120); key_raw = 1'b1; rel_q.push_back(n + 131);
    wait_until(n + 131); check("repeat_rel", key_level, 0);
    wait_until(n + 136);

    // Release glitch restarts the repeat delay.
    n = cyc;
    key_raw = 1'b0;
    press_q.push_back(n + 11);
    wait_until(n + 20); key_raw = 1'b1;
    wait_until(n + 23); key_raw = 1'b0;
    wait_until(n + 25); check("glitch_level_rw", key_level, 1);
    wait_until(n + 27); check("glitch_level_held", key_level, 1);
    press_q.push_back(n + 66);
    wait_until(n + 70); key_raw = 1'b1; rel_q.push_back(n + 81);
    wait_until(n + 86);

    // Reset two cycles after press_pulse, key kept held.
    n = cyc;
    key_raw = 1'b0;
    press_q.push_back(n + 11);
    wait_until(n + 13); reset_n = 1'b0;
    wait_until(n + 14);
    check("midreset_step", step_clock, 0);
    check("midreset_level", key_level, 0);
    n = cyc;
    reset_n = 1'b1;
    press_q.push_back(n + 11);
    wait_until(n + 10); check("midreset_relevel_pre", key_level, 0);
    wait_until(n + 11); check("midreset_relevel", key_level, 1);
    wait_until(n + 20); key_raw = 1'b1; rel_q.push_back(n + 31);
    wait_until(n + 36);

    check("press_q_empty", press_q.size(), 0);
    check("rel_q_empty", rel_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
